// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the data-memory port arbiter.
//               Holds the FSM state and owner encodings and the fixed
//               attributes of an instruction-fetch request.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    // Which requester owns the transaction currently in flight
    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_t;

    // Fetch is always a full-word read with no write data
    localparam logic [3:0]  IFU_BE    = 4'b1111;
    localparam logic [31:0] IFU_WDATA = 32'h0000_0000;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module      : arb_starve_cnt
// Description : Starvation guard for the fetch requester. Counts consecutive
//               LSU wins taken while fetch was also waiting, saturating at
//               STARVE_MAX, and raises o_force_ifu once the limit is reached.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_decide        - an arbitration decision is made this cycle
//               i_lsu_win       - the decision went to the LSU
//               i_ifu_req       - fetch was requesting at the decision
//               o_force_ifu     - fetch must win the next contested decision
// Revision    : 1.0 - initial release
// ============================================================================
module arb_starve_cnt #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_decide,
    input  logic i_lsu_win,
    input  logic i_ifu_req,
    output logic o_force_ifu
);

    localparam int unsigned     c_CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(STARVE_MAX);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_decide) begin
            // Any fetch win, or no fetch waiting, ends the starvation run
            if (!i_lsu_win || !i_ifu_req) begin
                r_cnt <= '0;
            end else if (r_cnt != c_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_force_ifu = (r_cnt == c_MAX);

endmodule : arb_starve_cnt
`default_nettype wire

// File: rtl/mem_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arb
// Description : Shares one data-memory port between instruction fetch (IFU,
//               read only) and the load/store unit (LSU). One transaction is
//               outstanding at a time: IDLE latches the winner, REQ presents
//               it to memory until mem_gnt, RESP waits for read data.
//               LSU wins by default. Defining ARB_STARVE_GUARD_EN adds a
//               starvation guard that forces a fetch win after STARVE_MAX
//               consecutive contested LSU wins.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               ifu_req/addr               - fetch request
//               ifu_gnt/rvalid/rdata       - fetch handshake and data
//               lsu_req/we/addr/wdata/be   - load/store request
//               lsu_gnt/rvalid/rdata       - load/store handshake and data
//               mem_req/we/addr/wdata/be   - memory request
//               mem_gnt/rvalid/rdata       - memory handshake and data
//               busy                       - FSM not idle
// Config      : `define ARB_STARVE_GUARD_EN enables the fetch starvation guard
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_gnt,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,

    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_be,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    arb_owner_t  r_owner;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    logic        w_latch;
    logic        w_lsu_win;
    logic        w_in_req;
    logic        w_in_resp;
    logic        w_gnt;
    logic        w_rvalid;

    assign w_latch   = (r_state == ARB_IDLE) && (ifu_req || lsu_req);
    assign w_in_req  = (r_state == ARB_REQ);
    assign w_in_resp = (r_state == ARB_RESP);
    // mem_gnt only counts in REQ, mem_rvalid only in RESP; stray pulses drop
    assign w_gnt     = w_in_req  && mem_gnt;
    assign w_rvalid  = w_in_resp && mem_rvalid;

`ifdef ARB_STARVE_GUARD_EN
    logic w_force_ifu;

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_decide    (w_latch),
        .i_lsu_win   (w_lsu_win),
        .i_ifu_req   (ifu_req),
        .o_force_ifu (w_force_ifu)
    );

    // The force flag only matters when fetch is actually contending
    assign w_lsu_win = lsu_req && !(w_force_ifu && ifu_req);
`else
    logic w_unused_starve_max;

    assign w_lsu_win           = lsu_req;
    assign w_unused_starve_max = ^STARVE_MAX;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_latch) begin
                    w_state_nxt = ARB_REQ;
                end
            end
            ARB_REQ: begin
                // Stores complete at grant; reads still owe a response
                if (mem_gnt) begin
                    w_state_nxt = r_we ? ARB_IDLE : ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (mem_rvalid) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request registers: captured once per transaction, held through REQ
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_IFU;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_be    <= 4'h0;
        end else if (w_latch) begin
            if (w_lsu_win) begin
                r_owner <= OWN_LSU;
                r_we    <= lsu_we;
                r_addr  <= lsu_addr;
                r_wdata <= lsu_wdata;
                r_be    <= lsu_be;
            end else begin
                r_owner <= OWN_IFU;
                r_we    <= 1'b0;
                r_addr  <= ifu_addr;
                r_wdata <= IFU_WDATA;
                r_be    <= IFU_BE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_req    = w_in_req;
    assign mem_we     = w_in_req ? r_we    : 1'b0;
    assign mem_addr   = w_in_req ? r_addr  : 32'h0;
    assign mem_wdata  = w_in_req ? r_wdata : 32'h0;
    assign mem_be     = w_in_req ? r_be    : 4'h0;

    assign ifu_gnt    = w_gnt    && (r_owner == OWN_IFU);
    assign lsu_gnt    = w_gnt    && (r_owner == OWN_LSU);
    assign ifu_rvalid = w_rvalid && (r_owner == OWN_IFU);
    assign lsu_rvalid = w_rvalid && (r_owner == OWN_LSU);
    assign ifu_rdata  = ifu_rvalid ? mem_rdata : 32'h0;
    assign lsu_rdata  = lsu_rvalid ? mem_rdata : 32'h0;

    assign busy       = (r_state != ARB_IDLE);

endmodule : mem_port_arb
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arb
// Description : Directed self-checking bench for mem_port_arb. Inputs change
//               1 time unit after the rising edge; outputs are sampled 1
//               unit later, well away from the next edge.
// Config      : expected grant order follows ARB_STARVE_GUARD_EN
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arb;

    logic        clk;
    logic        rst_n;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_gnt;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        lsu_req;
    logic        lsu_we;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_be;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_port_arb #(
        .STARVE_MAX (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ifu_req    (ifu_req),
        .ifu_addr   (ifu_addr),
        .ifu_gnt    (ifu_gnt),
        .ifu_rvalid (ifu_rvalid),
        .ifu_rdata  (ifu_rdata),
        .lsu_req    (lsu_req),
        .lsu_we     (lsu_we),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_be     (lsu_be),
        .lsu_gnt    (lsu_gnt),
        .lsu_rvalid (lsu_rvalid),
        .lsu_rdata  (lsu_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req    = 1'b0;
        ifu_addr   = 32'h0;
        lsu_req    = 1'b0;
        lsu_we     = 1'b0;
        lsu_addr   = 32'h0;
        lsu_wdata  = 32'h0;
        lsu_be     = 4'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"},  {31'h0, mem_req},    32'h0);
        chk({tag, "_mem_addr"}, mem_addr,            32'h0);
        chk({tag, "_mem_be"},   {28'h0, mem_be},     32'h0);
        chk({tag, "_gnts"},     {30'h0, ifu_gnt, lsu_gnt}, 32'h0);
        chk({tag, "_rvalids"},  {30'h0, ifu_rvalid, lsu_rvalid}, 32'h0);
        chk({tag, "_rdata"},    ifu_rdata | lsu_rdata, 32'h0);
        chk({tag, "_busy"},     {31'h0, busy},       32'h0);
    endtask

    initial begin : stim
        int          n_gnt;
        logic [5:0]  seq;
        logic [5:0]  seq_exp;

        clear_inputs();
        rst_n = 1'b0;

        // ---------------- reset state ----------------
        tick();
        settle();
        chk_all_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- IFU read ----------------
        ifu_req  = 1'b1;
        ifu_addr = 32'h100;
        settle();
        chk("ifu_c0_mem_req", {31'h0, mem_req}, 32'h0);
        tick();
        mem_gnt = 1'b1;
        settle();
        chk("ifu_c1_mem_req",  {31'h0, mem_req}, 32'h1);
        chk("ifu_c1_mem_addr", mem_addr, 32'h100);
        chk("ifu_c1_mem_be",   {28'h0, mem_be}, 32'hF);
        chk("ifu_c1_mem_we",   {31'h0, mem_we}, 32'h0);
        chk("ifu_c1_ifu_gnt",  {31'h0, ifu_gnt}, 32'h1);
        chk("ifu_c1_lsu_gnt",  {31'h0, lsu_gnt}, 32'h0);
        tick();
        ifu_req    = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        settle();
        chk("ifu_c2_rvalid",     {31'h0, ifu_rvalid}, 32'h1);
        chk("ifu_c2_rdata",      ifu_rdata, 32'hDEADBEEF);
        chk("ifu_c2_lsu_rvalid", {31'h0, lsu_rvalid}, 32'h0);
        chk("ifu_c2_lsu_rdata",  lsu_rdata, 32'h0);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("ifu_c3_busy", {31'h0, busy}, 32'h0);

        // ---------------- contention: LSU load then IFU ----------------
        tick();
        ifu_req  = 1'b1;
        ifu_addr = 32'h100;
        lsu_req  = 1'b1;
        lsu_we   = 1'b0;
        lsu_addr = 32'h200;
        lsu_be   = 4'hF;
        tick();
        mem_gnt = 1'b1;
        settle();
        chk("both_c1_mem_addr", mem_addr, 32'h200);
        chk("both_c1_lsu_gnt",  {31'h0, lsu_gnt}, 32'h1);
        chk("both_c1_ifu_gnt",  {31'h0, ifu_gnt}, 32'h0);
        tick();
        lsu_req    = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h11112222;
        settle();
        chk("both_c2_lsu_rvalid", {31'h0, lsu_rvalid}, 32'h1);
        chk("both_c2_lsu_rdata",  lsu_rdata, 32'h11112222);
        chk("both_c2_ifu_rvalid", {31'h0, ifu_rvalid}, 32'h0);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("both_c3_busy", {31'h0, busy}, 32'h0);
        tick();
        mem_gnt = 1'b1;
        settle();
        chk("both_c4_mem_addr", mem_addr, 32'h100);
        chk("both_c4_ifu_gnt",  {31'h0, ifu_gnt}, 32'h1);
        tick();
        ifu_req    = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h33334444;
        settle();
        chk("both_c5_ifu_rvalid", {31'h0, ifu_rvalid}, 32'h1);
        chk("both_c5_ifu_rdata",  ifu_rdata, 32'h33334444);
        chk("both_c5_lsu_rvalid", {31'h0, lsu_rvalid}, 32'h0);
        tick();
        clear_inputs();
        tick();

        // ---------------- LSU store byte ----------------
        lsu_req   = 1'b1;
        lsu_we    = 1'b1;
        lsu_be    = 4'b0001;
        lsu_addr  = 32'h203;
        lsu_wdata = 32'hAB;
        tick();
        mem_gnt = 1'b1;
        settle();
        chk("sb_mem_we",    {31'h0, mem_we}, 32'h1);
        chk("sb_mem_be",    {28'h0, mem_be}, 32'h1);
        chk("sb_mem_wdata", mem_wdata, 32'hAB);
        chk("sb_mem_addr",  mem_addr, 32'h203);
        chk("sb_lsu_gnt",   {31'h0, lsu_gnt}, 32'h1);
        tick();
        clear_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h99;
        settle();
        chk("sb_after_busy",   {31'h0, busy}, 32'h0);
        chk("sb_after_rvalid", {30'h0, ifu_rvalid, lsu_rvalid}, 32'h0);
        tick();
        clear_inputs();

        // ---------------- withheld mem_gnt ----------------
        lsu_req   = 1'b1;
        lsu_we    = 1'b1;
        lsu_be    = 4'b1100;
        lsu_addr  = 32'h300;
        lsu_wdata = 32'hCAFE0000;
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_mem_req",   {31'h0, mem_req}, 32'h1);
            chk("stall_mem_attrs", mem_addr ^ mem_wdata ^ {27'h0, mem_we, mem_be}, 32'h300 ^ 32'hCAFE0000 ^ 32'h1C);
            chk("stall_lsu_gnt",   {31'h0, lsu_gnt}, 32'h0);
            tick();
        end
        mem_gnt = 1'b1;
        settle();
        chk("stall_c4_mem_addr",  mem_addr, 32'h300);
        chk("stall_c4_mem_wdata", mem_wdata, 32'hCAFE0000);
        chk("stall_c4_lsu_gnt",   {31'h0, lsu_gnt}, 32'h1);
        tick();
        clear_inputs();
        tick();

        // ---------------- starvation behaviour ----------------
        ifu_req    = 1'b1;
        ifu_addr   = 32'h500;
        lsu_req    = 1'b1;
        lsu_we     = 1'b1;
        lsu_be     = 4'hF;
        lsu_addr   = 32'h600;
        lsu_wdata  = 32'h1;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        n_gnt      = 0;
        seq        = 6'h0;
        for (int cyc = 0; cyc < 60 && n_gnt < 6; cyc++) begin
            settle();
            if (ifu_gnt || lsu_gnt) begin
                seq[n_gnt] = ifu_gnt;
                n_gnt++;
            end
            tick();
        end
`ifdef ARB_STARVE_GUARD_EN
        seq_exp = 6'b100100;
`else
        seq_exp = 6'b000000;
`endif
        chk("starve_grant_count", n_gnt, 32'd6);
        chk("starve_grant_order", {26'h0, seq}, {26'h0, seq_exp});
        clear_inputs();
        tick();
        tick();
        tick();

        // ---------------- reset mid-response ----------------
        ifu_req  = 1'b1;
        ifu_addr = 32'h400;
        tick();
        mem_gnt = 1'b1;
        settle();
        chk("rst_c1_ifu_gnt", {31'h0, ifu_gnt}, 32'h1);
        tick();
        clear_inputs();
        settle();
        chk("rst_c2_busy_before", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        settle();
        chk_all_zero("rst_mid");
        tick();
        rst_n = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55;
        settle();
        chk_all_zero("rst_after");
        tick();
        clear_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_port_arb
`default_nettype wire

// File: doc/mem_port_arb.md
# mem_port_arb

Two-requester arbiter that shares the single data-memory port between instruction fetch (IFU, read-only) and the load/store path (LSU, read/write with byte enables for SB/SW). Sits between the core's fetch/LSU logic and the memory. Serialises one outstanding transaction at a time through a 3-state FSM. LSU has priority by default, with an optional starvation guard for fetch.

## Interface
- `STARVE_MAX`, 4, number of consecutive LSU wins over a pending IFU before IFU is forced to win; used only with the guard enabled.
- `clk  in  1`  clock, rising edge.
- `rst_n  in  1`  asynchronous, active-low reset.
- `ifu_req  in  1`  fetch request; held until `ifu_gnt`.
- `ifu_addr  in  32`  fetch byte address.
- `ifu_gnt  out  1`  fetch request accepted by memory (1-cycle pulse).
- `ifu_rvalid  out  1`  fetch data valid (1-cycle pulse).
- `ifu_rdata  out  32`  fetch data.
- `lsu_req  in  1`  load/store request; held until `lsu_gnt`.
- `lsu_we  in  1`  1 = store.
- `lsu_addr  in  32`  byte address.
- `lsu_wdata  in  32`  store data.
- `lsu_be  in  4`  byte enables.
- `lsu_gnt  out  1`  LSU request accepted.
- `lsu_rvalid  out  1`  load data valid.
- `lsu_rdata  out  32`  load data.
- `mem_req  out  1`  request to memory.
- `mem_we  out  1`  memory write enable.
- `mem_addr  out  32`  memory address.
- `mem_wdata  out  32`  memory write data.
- `mem_be  out  4`  memory byte enables.
- `mem_gnt  in  1`  memory accepts the request this cycle.
- `mem_rvalid  in  1`  memory read data valid.
- `mem_rdata  in  32`  memory read data.
- `busy  out  1`  FSM not in ARB_IDLE.

## Operation
- States: ARB_IDLE, ARB_REQ, ARB_RESP. Owner register: OWN_IFU or OWN_LSU.
- ARB_IDLE, any request present:
  - Select the winner.
  - Latch the winner's address, we, wdata and be into the request registers.
  - Go to ARB_REQ.
- Winner selection: LSU if `lsu_req`, otherwise IFU. IFU request attributes are fixed: we=0, be=4'b1111, wdata=0.
- ARB_REQ:
  - `mem_req`=1; `mem_*` outputs driven from the latched registers.
  - On `mem_gnt`: owner's gnt = 1 in that same cycle (combinational).
  - After `mem_gnt`: a store goes to ARB_IDLE; a load or fetch goes to ARB_RESP.
- ARB_RESP:
  - On `mem_rvalid`: owner's rvalid = 1 and owner's rdata = `mem_rdata`, same cycle (combinational).
  - Then go to ARB_IDLE.
- Non-owner rvalid/gnt always 0. Both rdata outputs are 0 whenever not valid.
- `mem_rvalid` in ARB_IDLE/ARB_REQ and `mem_gnt` outside ARB_REQ are ignored.
- A requester that drops req before its gnt violates the protocol. The arbiter still completes the latched transaction; the gnt pulse goes to the owner regardless.
- Reset (any state, including mid-transaction):
  - FSM to ARB_IDLE; the outstanding transaction is abandoned.
  - Every output 0; latched registers and starvation count 0.
  - A `mem_rvalid` arriving after reset release is ignored, because the FSM is in ARB_IDLE.

## Timing
- Req sampled in cycle N, ARB_IDLE → `mem_req` asserted in cycle N+1.
- Best case: `mem_gnt` in N+1, so requester gnt in N+1. Earliest rvalid is N+2 (memory returns data at least one cycle after gnt).
- Back to back: after completion the FSM spends one cycle in ARB_IDLE before it can latch the next request. Minimum issue interval: 2 cycles for stores, 3 cycles for reads.
- `mem_req` and all `mem_*` attributes stay stable throughout ARB_REQ until `mem_gnt`, with unbounded wait.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - Counter width is $clog2(STARVE_MAX+1).
  - Increments when LSU wins while `ifu_req`=1; saturates at STARVE_MAX.
  - Cleared when IFU wins, or when `ifu_req`=0 at an arbitration decision.
  - When count==STARVE_MAX and both requesters are pending, IFU wins.
- `ARB_STARVE_GUARD_EN` undefined: strict LSU priority; no counter logic exists; `STARVE_MAX` is unused.

## Structure
- Shared package `mem_arb_pkg`:
  - `arb_state_t` enum {ARB_IDLE, ARB_REQ, ARB_RESP}.
  - `arb_owner_t` enum {OWN_IFU, OWN_LSU}.
  - `IFU_BE` = 4'b1111.
- One sub-module, `arb_starve_cnt`: the saturating counter plus the force-IFU flag, instantiated only under `ARB_STARVE_GUARD_EN`.

## Test plan
- IFU read, addr 0x100; `mem_gnt` in cycle 1, `mem_rvalid` in cycle 2 with 0xDEADBEEF → `mem_req` in cycle 1 with `mem_addr`=0x100, `mem_be`=4'hF; `ifu_gnt` in cycle 1; `ifu_rvalid` with `ifu_rdata`=0xDEADBEEF in cycle 2; `lsu_rvalid` stays 0.
- IFU (0x100) and LSU load (0x200) both request in cycle 0 → `mem_addr`=0x200 first and `lsu_rvalid` fires; then `mem_addr`=0x100 and `ifu_rvalid` fires.
- LSU store, SB: we=1, be=4'b0001, addr 0x203, wdata 0xAB → `mem_we`=1, `mem_be`=0001, `mem_wdata`=0xAB; `lsu_gnt` with `mem_gnt`; FSM back to ARB_IDLE next cycle; no rvalid.
- `mem_gnt` withheld for 3 cycles → `mem_req` and all attributes constant for 4 cycles; no gnt until `mem_gnt`.
- `ARB_STARVE_GUARD_EN` with STARVE_MAX=2; LSU requests continuously and IFU stays pending → grant order LSU, LSU, IFU, LSU, LSU, IFU. Without the macro → IFU is never granted.
- `rst_n` pulsed low in ARB_RESP, then `mem_rvalid` arrives after release → all outputs 0 and `busy`=0; no rvalid pulse to either requester.
